// File: rtl/serial_lane_arbiter.sv
// Round-robin arbiter and serializer for one shared 1-bit lane carrying 4-bit frames.
// A frame is 4 data cycles (LSB first) followed by a single guard cycle.
module serial_lane_arbiter #(
    parameter int N_REQ = 4,
    parameter int CW    = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] data_in,
    output logic [N_REQ-1:0]   gnt,
    output logic [CW-1:0]      owner,
    output logic               busy,
    output logic               tx,
    output logic               tx_valid,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    owner_q, owner_d;
    logic [2:0]       shreg_q, shreg_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;

    logic [CW-1:0]    winner;
    logic             found;
    logic             grant;
    logic [3:0]       nibble;
    int               idx;

    // Scan ptr, ptr+1, ... wrapping at N_REQ; first asserted request wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = CW'(idx);
            end
        end
    end

    assign grant  = (state_q != SHIFT) && en && found;
    assign nibble = data_in[{winner, 2'b00} +: 4];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        shreg_d = shreg_q;
        gnt_d   = '0;
        busy_d  = 1'b0;
        tx_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            SHIFT: begin
                if (cnt_q != 2'd3) begin
                    cnt_d   = cnt_q + 2'd1;
                    busy_d  = 1'b1;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end else begin
                    state_d = GAP;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A grant out of GAP goes straight back into SHIFT.
        if (grant) begin
            state_d       = SHIFT;
            cnt_d         = 2'd0;
            owner_d       = winner;
            ptr_d         = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
            gnt_d[winner] = 1'b1;
            busy_d        = 1'b1;
            tx_d          = nibble[0];
            shreg_d       = nibble[3:1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            shreg_q <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            tx_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            shreg_q <= shreg_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign gnt      = gnt_q;
    assign owner    = owner_q;
    assign busy     = busy_q;
    assign tx       = tx_q;
    assign tx_valid = busy_q;
    assign done     = done_q;

endmodule
